// File: rtl/ds1302_responder.sv
// rtl/ds1302_responder.sv - DS1302-compatible 3-wire slave with BCD timekeeping
//
// Purpose:
//   Answers the DS1302 CE/SCLK/SIO protocol as a clock chip would. It holds the
//   seconds, minutes, hours and control (WP) registers and advances time from a
//   1 Hz tick derived from CLK.
//
// Optional feature:
//   `define DS1302_RAM_EN adds a 31-byte scratch RAM at cmd[6] = 1.
//   Without it, every RAM-space command acts on an unimplemented address.
//
// Parameters:
//   CLK_HZ       CLK frequency; one seconds tick every CLK_HZ cycles
//
// Ports:
//   CLK          system clock
//   RST          synchronous active-high reset
//   DS_RST       DS1302 CE from the master (asynchronous)
//   DS_SCLK      DS1302 serial clock from the master (asynchronous)
//   DS_SIO       DS1302 data; driven only while read data is returned
//   Time_second  {CH, BCD seconds}
//   Time_minute  BCD minutes
//   Time_hour    BCD hours (24 h)
//   Sec_tick     one-CLK pulse for each applied seconds increment
//   Wp           write-protect bit of the control register
module ds1302_responder #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DS_RST,
  input  logic       DS_SCLK,
  inout  wire        DS_SIO,
  output logic [7:0] Time_second,
  output logic [7:0] Time_minute,
  output logic [7:0] Time_hour,
  output logic       Sec_tick,
  output logic       Wp
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, IGNORE} state_t;

  state_t state, state_nxt;

  // Input synchronizers
  logic [1:0] ce_ff, sclk_ff, sio_ff;
  logic       sclk_d;
  logic       ce_s, sclk_s, sio_s, rise, fall;

  // Protocol datapath
  logic [7:0] cmd, cmd_shift, wdata, rd_sr, rd_val;
  logic [4:0] bit_cnt;
  logic [4:0] addr;
  logic       sio_oe, sio_q;

  // Registers and timekeeping
  logic [7:0]    sec_r, min_r, hr_r, ctrl_r;
  logic [PW-1:0] prescaler;
  logic          tick_r;
  logic          commit, clk_space;
  logic          wr_sec, wr_min, wr_hr, wr_ctrl, wr_time;
  logic          wrap, tick_apply;
  logic [7:0]    sec_inc, min_inc, hr_inc;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      ce_ff   <= 2'b00;
      sclk_ff <= 2'b00;
      sio_ff  <= 2'b00;
      sclk_d  <= 1'b0;
    end else begin
      ce_ff   <= {ce_ff[0], DS_RST};
      sclk_ff <= {sclk_ff[0], DS_SCLK};
      sio_ff  <= {sio_ff[0], DS_SIO};
      sclk_d  <= sclk_ff[1];
    end
  end

  assign ce_s   = ce_ff[1];
  assign sclk_s = sclk_ff[1];
  assign sio_s  = sio_ff[1];
  assign rise   = sclk_s & ~sclk_d;
  assign fall   = ~sclk_s & sclk_d;

  // Command byte as it stands once the bit on this rising edge is shifted in;
  // the 8th-edge decision and the read snapshot both use it.
  assign cmd_shift = {sio_s, cmd[7:1]};
  assign addr      = cmd[5:1];
  assign clk_space = ~cmd[6];

`ifdef DS1302_RAM_EN
  logic [7:0] ram [0:30];
  logic       ram_wr;

  assign ram_wr = commit && cmd[6] && !ctrl_r[7] && (addr != 5'd31);

  always_ff @(posedge CLK) begin
    if (ram_wr) ram[addr] <= wdata;
  end
`endif

  always_comb begin
    rd_val = 8'h00;
    if (!cmd_shift[6]) begin
      case (cmd_shift[5:1])
        5'd0:    rd_val = sec_r;
        5'd1:    rd_val = min_r;
        5'd2:    rd_val = hr_r;
        5'd7:    rd_val = ctrl_r;
        default: rd_val = 8'h00;
      endcase
    end
`ifdef DS1302_RAM_EN
    else if (cmd_shift[5:1] != 5'd31) begin
      rd_val = ram[cmd_shift[5:1]];
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (ce_s) state_nxt = CMD;
      CMD: begin
        if (rise && bit_cnt == 5'd7) begin
          if (!cmd_shift[7])    state_nxt = IGNORE;
          else if (cmd_shift[0]) state_nxt = RDATA;
          else                   state_nxt = WDATA;
        end
      end
      WDATA:  if (bit_cnt == 5'd16) state_nxt = IGNORE;
      RDATA:  if (fall && bit_cnt == 5'd16) state_nxt = IGNORE;
      IGNORE: state_nxt = IGNORE;
      default: state_nxt = IDLE;
    endcase
    // CE low overrides everything, including a write about to commit
    if (!ce_s) state_nxt = IDLE;
  end

  // bit_cnt runs 0..7 over the command, 8..16 over write data, and 8..16 over
  // read falling edges (8 = first edge drives bit0, 16 = edge that releases).
  always_ff @(posedge CLK) begin
    if (RST) begin
      cmd     <= 8'h00;
      wdata   <= 8'h00;
      rd_sr   <= 8'h00;
      bit_cnt <= 5'd0;
      sio_oe  <= 1'b0;
      sio_q   <= 1'b0;
    end else if (!ce_s) begin
      bit_cnt <= 5'd0;
      sio_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE: bit_cnt <= 5'd0;
        CMD: begin
          if (rise) begin
            cmd     <= cmd_shift;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) rd_sr <= rd_val;
          end
        end
        WDATA: begin
          if (rise && bit_cnt < 5'd16) begin
            wdata   <= {sio_s, wdata[7:1]};
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        RDATA: begin
          if (fall) begin
            if (bit_cnt == 5'd16) begin
              sio_oe <= 1'b0;
            end else begin
              sio_oe  <= 1'b1;
              sio_q   <= rd_sr[0];
              rd_sr   <= {1'b0, rd_sr[7:1]};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign DS_SIO = sio_oe ? sio_q : 1'bz;

  assign commit  = (state == WDATA) && (bit_cnt == 5'd16) && ce_s && !cmd[0];
  assign wr_ctrl = commit && clk_space && (addr == 5'd7);
  assign wr_sec  = commit && clk_space && !ctrl_r[7] && (addr == 5'd0);
  assign wr_min  = commit && clk_space && !ctrl_r[7] && (addr == 5'd1);
  assign wr_hr   = commit && clk_space && !ctrl_r[7] && (addr == 5'd2);
  assign wr_time = wr_sec | wr_min | wr_hr;

  // A time-register write in the wrap cycle swallows that tick completely.
  assign wrap       = !sec_r[7] && (prescaler == PRE_MAX);
  assign tick_apply = wrap && !wr_time;

  assign sec_inc = bcd_inc({1'b0, sec_r[6:0]});
  assign min_inc = bcd_inc(min_r);
  assign hr_inc  = bcd_inc(hr_r);

  always_ff @(posedge CLK) begin
    if (RST) begin
      sec_r     <= 8'h80;
      min_r     <= 8'h00;
      hr_r      <= 8'h00;
      ctrl_r    <= 8'h80;
      prescaler <= '0;
      tick_r    <= 1'b0;
    end else begin
      tick_r <= tick_apply;

      if (wr_time) begin
        if (wr_sec) sec_r <= wdata;
        if (wr_min) min_r <= wdata;
        if (wr_hr)  hr_r  <= {1'b0, wdata[6:0]};
      end else if (tick_apply) begin
        if (sec_r[6:0] == 7'h59) begin
          sec_r <= {sec_r[7], 7'h00};
          if (min_r == 8'h59) begin
            min_r <= 8'h00;
            hr_r  <= (hr_r == 8'h23) ? 8'h00 : hr_inc;
          end else begin
            min_r <= min_inc;
          end
        end else begin
          sec_r <= {sec_r[7], sec_inc[6:0]};
        end
      end

      if (wr_ctrl) ctrl_r <= wdata;

      if (wr_sec || sec_r[7] || wrap) prescaler <= '0;
      else                            prescaler <= prescaler + PW'(1);
    end
  end

  assign Time_second = sec_r;
  assign Time_minute = min_r;
  assign Time_hour   = hr_r;
  assign Sec_tick    = tick_r;
  assign Wp          = ctrl_r[7];

endmodule

// File: tb/tb_ds1302_responder.sv
// tb/tb_ds1302_responder.sv - directed self-checking bench for ds1302_responder
module tb_ds1302_responder;

  localparam int HZ = 10;

`ifdef DS1302_RAM_EN
  localparam logic [7:0] RAM_EXP = 8'h5A;
`else
  localparam logic [7:0] RAM_EXP = 8'h00;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       DS_RST;
  logic       DS_SCLK;
  wire        DS_SIO;
  logic [7:0] Time_second, Time_minute, Time_hour;
  logic       Sec_tick, Wp;

  logic tb_sio_en, tb_sio;
  assign DS_SIO = tb_sio_en ? tb_sio : 1'bz;

  ds1302_responder #(.CLK_HZ(HZ)) dut (
    .CLK(CLK), .RST(RST), .DS_RST(DS_RST), .DS_SCLK(DS_SCLK), .DS_SIO(DS_SIO),
    .Time_second(Time_second), .Time_minute(Time_minute), .Time_hour(Time_hour),
    .Sec_tick(Sec_tick), .Wp(Wp)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_total = 0;
  int rise16_cyc = -1;
  int k_ref = 0;
  logic align_en = 1'b0;

  // cyc counts CLK posedges; ticks are sampled 1 time unit after each edge
  always begin
    @(posedge CLK);
    cyc = cyc + 1;
    #1;
    if (Sec_tick) tick_total = tick_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait4();
    repeat (4) @(negedge CLK);
  endtask

  task automatic ce_begin();
    DS_SCLK   = 1'b0;
    DS_RST    = 1'b1;
    tb_sio_en = 1'b1;
    wait4();
  endtask

  task automatic ce_end();
    DS_SCLK = 1'b0;
    wait4();
    DS_RST    = 1'b0;
    tb_sio_en = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    tb_sio  = b;
    DS_SCLK = 1'b0;
    wait4();
    DS_SCLK = 1'b1;
    wait4();
  endtask

  // nbits < 16 aborts the write by dropping CE early
  task automatic ds_write(input logic [7:0] c, input logic [7:0] d, input int nbits);
    logic [15:0] w;
    int n;
    w = {d, c};
    ce_begin();
    for (int i = 0; i < nbits; i++) begin
      tb_sio  = w[i];
      DS_SCLK = 1'b0;
      wait4();
      if (i == 15) begin
        n = 0;
        // commit lands 4 posedges after the pin rise; line it up with a wrap
        while (align_en && ((cyc + 4 - k_ref) % HZ != 0) && n < 50) begin
          @(negedge CLK);
          n++;
        end
        rise16_cyc = cyc;
      end
      DS_SCLK = 1'b1;
      wait4();
    end
    ce_end();
  endtask

  task automatic ds_read(input logic [7:0] c, output logic [7:0] v, output logic released);
    ce_begin();
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    tb_sio_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      DS_SCLK = 1'b0;
      wait4();
      v[i] = DS_SIO;
      DS_SCLK = 1'b1;
      wait4();
    end
    DS_SCLK = 1'b0;
    wait4();
    released = !dut.sio_oe;
    DS_SCLK = 1'b1;
    wait4();
    ce_end();
  endtask

  task automatic wait_rise16();
    int n = 0;
    while (rise16_cyc < 0 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    chk("rise16_seen", rise16_cyc >= 0, 1);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    @(negedge CLK);
    while (cyc < target && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_cyc", cyc, target);
  endtask

  logic [7:0] rv;
  logic       rel;
  logic       drive_seen;
  int         k, t0;

  initial begin
    RST = 1'b1; DS_RST = 1'b0; DS_SCLK = 1'b0; tb_sio_en = 1'b0; tb_sio = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    chk("rst_sec",  Time_second, 8'h80);
    chk("rst_min",  Time_minute, 8'h00);
    chk("rst_hr",   Time_hour,   8'h00);
    chk("rst_wp",   Wp,          1'b1);
    chk("rst_tick", Sec_tick,    1'b0);
    chk("rst_oe",   dut.sio_oe,  1'b0);

    ds_read(8'h81, rv, rel);
    chk("rd_sec", rv, 8'h80);
    chk("rd_release", rel, 1'b1);
    ds_read(8'h8F, rv, rel);
    chk("rd_ctrl", rv, 8'h80);

    ds_write(8'h82, 8'h49, 16);
    chk("wp_block_min", Time_minute, 8'h00);
    ds_write(8'h8E, 8'h00, 16);
    chk("wp_clear", Wp, 1'b0);
    ds_write(8'h82, 8'h49, 16);
    chk("wr_min", Time_minute, 8'h49);

    ds_read(8'h83, rv, rel);
    chk("rd_min", rv, 8'h49);
    ds_read(8'h87, rv, rel);
    chk("rd_unimpl", rv, 8'h00);
    ds_write(8'hC0, 8'h5A, 16);
    ds_read(8'hC1, rv, rel);
    chk("rd_ram", rv, RAM_EXP);

    ds_write(8'h84, 8'h92, 16);
    chk("wr_hr_24h", Time_hour, 8'h12);

    ds_write(8'h80, 8'h00, 12);
    chk("abort_sec", Time_second, 8'h80);
    ds_read(8'h81, rv, rel);
    chk("after_abort_rd", rv, 8'h80);

    // bit7 clear: no response to a read command, no effect of a write command
    ce_begin();
    for (int i = 0; i < 8; i++) send_bit(i == 0);
    tb_sio_en  = 1'b0;
    drive_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      DS_SCLK = 1'b0;
      wait4();
      drive_seen = drive_seen | dut.sio_oe;
      DS_SCLK = 1'b1;
      wait4();
    end
    ce_end();
    chk("ign_drive", drive_seen, 1'b0);
    chk("ign_sec", Time_second, 8'h80);
    chk("ign_min", Time_minute, 8'h49);
    chk("ign_hr",  Time_hour,   8'h12);
    ds_write(8'h02, 8'h11, 16);
    chk("ign_wr_min", Time_minute, 8'h49);

    // Rollover: 23:59:58 -> 23:59:59 -> 00:00:00
    ds_write(8'h84, 8'h23, 16);
    ds_write(8'h82, 8'h59, 16);
    rise16_cyc = -1;
    fork
      ds_write(8'h80, 8'h58, 16);
      begin
        wait_rise16();
        k = rise16_cyc + 4;
        k_ref = k;
        wait_cyc(k);
        chk("commit_sec", Time_second, 8'h58);
        t0 = tick_total;
        wait_cyc(k + 9);
        chk("pre_tick_sec", Time_second, 8'h58);
        wait_cyc(k + 10);
        chk("t1_sec",  Time_second, 8'h59);
        chk("t1_min",  Time_minute, 8'h59);
        chk("t1_hr",   Time_hour,   8'h23);
        chk("t1_tick", Sec_tick,    1'b1);
        wait_cyc(k + 20);
        chk("t2_sec", Time_second, 8'h00);
        chk("t2_min", Time_minute, 8'h00);
        chk("t2_hr",  Time_hour,   8'h00);
        chk("t2_ticks", tick_total - t0, 2);
      end
    join

    // Seconds commit in the same CLK as a prescaler wrap
    rise16_cyc = -1;
    align_en   = 1'b1;
    fork
      ds_write(8'h80, 8'h45, 16);
      begin
        wait_rise16();
        k = rise16_cyc + 4;
        wait_cyc(k);
        chk("col_sec",  Time_second,   8'h45);
        chk("col_tick", Sec_tick,      1'b0);
        chk("col_pre",  dut.prescaler, 0);
        wait_cyc(k + 9);
        chk("col_hold", Time_second, 8'h45);
        wait_cyc(k + 10);
        chk("col_next", Time_second, 8'h46);
      end
    join
    align_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ds1302_responder.md
Name: ds1302_responder

Overview:
- Synthesizable DS1302-compatible slave that answers on the 3-wire CE/SCLK/SIO bus, as the counterpart to the existing DS1302 master.
- Used for in-FPGA emulation of the RTC chip and for loopback bring-up of the master.
- Holds BCD seconds/minutes/hours plus the control (WP) register.
- Keeps time from a CLK-derived 1 Hz tick and exposes the current time for debug.

Parameters:
- CLK_HZ, 50_000_000, CLK frequency; the prescaler counts 0..CLK_HZ-1 per 1 s tick.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- DS_RST  in  1  DS1302 CE from master (asynchronous)
- DS_SCLK  in  1  DS1302 serial clock from master (asynchronous)
- DS_SIO  inout  1  DS1302 data; driven only while a read is returning data, otherwise Z
- Time_second  out  8  seconds register {CH, BCD 00-59}
- Time_minute  out  8  minutes register, BCD 00-59
- Time_hour  out  8  hours register, BCD 00-23
- Sec_tick  out  1  1-CLK pulse on each applied 1 s increment
- Wp  out  1  control register bit7

Behaviour:
- Interface decisions: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values:
  - seconds 0x80 (CH=1, halted); minutes 0x00; hours 0x00; control 0x80 (WP=1).
  - Prescaler 0; Sec_tick 0; SIO released; protocol FSM in IDLE.
- Input sync and edge detection:
  - DS_RST, DS_SCLK and DS_SIO each pass through 2-FF synchronizers.
  - SCLK edges are detected on the synchronized signal.
  - The master guarantees SCLK high and low each ≥4 CLK.
- FSM states: IDLE, CMD, WDATA, RDATA, IGNORE.
- IDLE → CMD when synchronized CE = 1. Bit counter = 0.
- CMD:
  - Samples SIO on each SCLK rising edge, LSB first, into cmd[7:0].
  - Field meanings: cmd[0] 1 = read; cmd[5:1] = address; cmd[6] 0 = clock; cmd[7] must be 1.
  - After the 8th rising edge:
    - cmd[7] = 0 → IGNORE.
    - Write → WDATA.
    - Read → snapshot the addressed register into a shift register, then → RDATA.
- WDATA:
  - Samples 8 data bits on rising edges, LSB first.
  - Commit happens on the CLK after the 16th rising edge is detected.
  - Address map: 0 seconds, 1 minutes, 2 hours, 7 control.
  - With WP=1, writes to 0..2 are discarded; writes to control are always accepted.
  - Unimplemented addresses: writes discarded.
  - Hours bit7 (12/24 mode) is stored as 0. Values are stored exactly as written; BCD legality is not checked.
  - After commit → IGNORE.
- RDATA:
  - Output enable asserts and bit0 is driven on the first SCLK falling edge after the command.
  - Each subsequent falling edge shifts out the next bit.
  - After bit7 has been held through one more falling edge, SIO is released → IGNORE.
  - Reads of unimplemented addresses return 0x00.
  - Max latency from SCLK fall (pin) to SIO change is 4 CLK.
- IGNORE: hold until CE = 0.
- CE low at any time:
  - Next CLK (after sync): FSM → IDLE, SIO released, bit counter cleared.
  - A partial write is aborted with no register change.
- Timekeeping:
  - When CH = 0, the prescaler increments every CLK; at CLK_HZ-1 it wraps to 0 and a tick is generated.
  - Tick: seconds BCD+1; 59 → 00 carries to minutes; minutes 59 → 00 carries to hours; hours 23 → 00.
  - When CH = 1, the prescaler is held at 0 and no ticks occur.
  - Any committed write to seconds clears the prescaler.
  - If a commit and a tick occur in the same CLK, the commit wins and the tick is dropped entirely; Sec_tick stays 0.
  - Sec_tick pulses only for applied ticks.

Optional Feature:
- Macro DS1302_RAM_EN.
- When defined:
  - Adds 31×8 scratch RAM at cmd[6] = 1, addresses 0..30 (cmd 0xC0/0xC1 .. 0xFC/0xFD).
  - RAM writes are subject to WP; reads follow the same RDATA timing.
  - Address 31 (RAM burst) is treated as unimplemented.
  - RAM content is not cleared by reset.
- When undefined: every cmd[6] = 1 command behaves as an unimplemented address (write ignored, read 0x00).

Test Plan:
- Reset, then read 0x81 → SIO returns 0x80. Read 0x8F → 0x80. Time outputs are 0x80/0x00/0x00; SIO is Z outside read data.
- With WP=1, write 0x82 data 0x49 → minutes stay 0x00. Write 0x8E data 0x00, then 0x82 data 0x49 → Time_minute = 0x49, Wp = 0.
- CLK_HZ = 10: write seconds 0x58, minutes 0x59, hours 0x23 → after 10 CLK all read 0x59/0x59/0x23. After 10 more CLK they read 0x00/0x00/0x00, with 2 Sec_tick pulses total.
- Drop CE after 12 SCLK bits of a write to 0x80 data 0x00 → no change (CH stays 1). The next full command still decodes correctly.
- Force a seconds write commit on the same CLK as a prescaler wrap → seconds = written value, prescaler = 0, Sec_tick = 0.
- Command 0x01 (bit7 = 0) followed by 8 clocks → no SIO drive and no register change.
